// File: rtl/serial_bit_transmitter.sv
// serial_bit_transmitter: parallel-in, serial-out frame transmitter.
// Frame = start bit (0), DATA_BITS data bits LSB first, optional even
// parity bit, stop bit (1); every bit is held for CLKS_PER_BIT clocks.
// Optional parity is enabled by defining the macro SERIAL_TX_PARITY_EN.
// tx_serial is a register fed from the current state, so the line trails
// the state machine by one clock (start bit appears the edge after accept).
module serial_bit_transmitter #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       baud_q, baud_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   serial_q, serial_d;
`ifdef SERIAL_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic                   bit_end;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign tx_ready  = (state_q == ST_IDLE);
   assign tx_busy   = (state_q != ST_IDLE);
   assign tx_serial = serial_q;

   // Next-state, counters, shift register and next line level
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      serial_d = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif

      // Baud counter runs in every non-idle state and wraps at period end
      if (state_q != ST_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            serial_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            if (tx_valid && tx_ready) begin
               shift_d  = tx_data;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ^tx_data;
`endif
               state_d  = ST_START;
            end
         end
         ST_START: begin
            serial_d = 1'b0;
            if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            serial_d = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         ST_PARITY: begin
            serial_d = parity_q;
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            serial_d = 1'b1;
            if (bit_end) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            serial_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame and idles the line high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: doc/serial_bit_transmitter.md
Name: serial_bit_transmitter

Overview:
- Parallel-in, serial-out transmitter. Frames a DATA_BITS-wide word as start bit, data bits LSB first, optional parity bit, then stop bit.
- Holds each bit on the line for CLKS_PER_BIT clocks.
- It is the driving end of the single-wire bit stream that the team's flip-flop based serial capture logic samples.
- Sits between a producer using a valid/ready handshake and the serial line.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, payload width per frame; legal range 1..16.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a word to send.
- tx_data  input  DATA_BITS  word to send; sampled only on the accept edge.
- tx_ready  output  1  high when the block can accept a word.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is on the line.

Behaviour:
- Reset: asynchronous, active-low; clk is the only clock.
  - Values while rst_n=0: tx_serial=1, tx_ready=1, tx_busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately, with no wait for a clock edge; the line returns high.
- Outputs are registered. tx_ready and tx_busy are decoded from state, and tx_ready = (state==IDLE).
- States: IDLE, START, DATA, PARITY (present only with the option), STOP.
- IDLE:
  - tx_serial=1.
  - Accept when tx_valid && tx_ready at a rising edge: latch tx_data into the shift register and go to START.
  - tx_valid while not ready is ignored; no queueing.
  - tx_data changes after the accept edge do not affect the frame in flight.
- Baud counter (width $clog2(CLKS_PER_BIT)):
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Each bit period ends when the count reaches CLKS_PER_BIT-1; the counter then wraps to 0 and the state advances.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_serial = shift register bit 0.
  - At the end of each bit period, shift right and increment the bit counter.
  - After DATA_BITS periods, go to PARITY if present, else to STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx_serial falls on the first edge after the accept edge.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles, or (DATA_BITS+3)*CLKS_PER_BIT with parity.
- Back-to-back frames:
  - After STOP, one IDLE cycle with tx_ready=1 and tx_serial=1.
  - If tx_valid is held high, the next start bit begins the cycle after that.
  - Minimum inter-frame gap is therefore 1 clock of idle-high.
- tx_busy=1 in START/DATA/PARITY/STOP and 0 in IDLE.
- No glitches on tx_serial: it is driven from a register, never from combinational decode.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Bit driven = even parity, the XOR of the latched word, computed at accept time and held in a register.
- Undefined:
  - The PARITY state and parity register are absent.
  - DATA goes directly to STOP.

Test Plan:
- Reset, no activity: hold rst_n=0 for 3 clocks, then release -> tx_serial=1, tx_ready=1, tx_busy=0 for 20 cycles with tx_valid=0.
- Single frame, CLKS_PER_BIT=4, DATA_BITS=8: send 0xA5 -> line reads 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 4 cycles; 40 busy cycles; tx_ready returns on cycle 41.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> exactly one idle-high cycle between the first stop bit and the second start bit; second frame is correct.
- Data stability: change tx_data to 0x3C two cycles after accepting 0xA5 -> transmitted bits still encode 0xA5. Pulsing tx_valid while busy is ignored.
- Mid-frame reset: assert rst_n=0 during bit 3 of DATA -> tx_serial=1 without waiting for a clk edge. After release, the IDLE outputs are correct and a new 0x81 frame transmits correctly.
- SERIAL_TX_PARITY_EN defined:
  - 0xA5 -> parity bit 0; 0x07 -> parity bit 1.
  - Each frame is 44 cycles.
